cu_strobe_arbiter: RTL and testbench
====================================

// Module: cu_strobe_arbiter
// PURPOSE
//  Round-robin scheduler sharing the cu decode strobe path among NREQ requesters.
//  Picks one requester, drives its 2-bit select code and a one-hot strobe, and
//  holds the grant until release. An inhibit input blocks new grants.
//  Sits ahead of the cu decoder and sequences which decoded strobe line is active.
// PARAMETERS
//  NREQ      4   number of requesters; power of two, 2..8
//  MAX_HOLD  16  grant watchdog limit in cycles; >=2; used only with CU_ARB_TIMEOUT_EN
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  req        in   NREQ         request level, one bit per requester
//  rel        in   NREQ         release pulse from the current owner
//  inhibit    in   1            1 = no new grant is issued; an active grant is kept
//  gnt        out  NREQ         one-hot grant, registered
//  gnt_idx    out  $clog2(NREQ) encoded owner (select code), registered
//  gnt_vld    out  1            gnt/gnt_idx are valid
//  strobe     out  1            1-cycle pulse in the first grant cycle
//  busy       out  1            FSM is not in IDLE
//  timeout    out  1            1-cycle pulse when the watchdog revokes a grant
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, ptr=NREQ-1 (so req[0] wins the first tie), hold counter 0.
//  FSM states: IDLE -> GRANT -> HOLD -> RECOVER -> IDLE.
//  IDLE: if !inhibit && |req, the winner is the first set req bit scanning ptr+1, ptr+2, ...
//    (mod NREQ). Next cycle: GRANT, with gnt, gnt_idx, gnt_vld=1 and strobe=1.
//    Latency from req to gnt is 1 cycle. With inhibit=1 or req=0, stay in IDLE.
//  GRANT: lasts exactly 1 cycle (strobe=1), then HOLD. Grant outputs stay stable.
//  HOLD: exit to RECOVER when rel[idx]=1 or req[idx]=0. Dropping the request counts
//    as a release. rel/req on bits other than idx are ignored.
//  Release during GRANT is deferred and acted on in the first HOLD cycle.
//  RECOVER: 1 dead cycle with gnt=0 and gnt_vld=0; ptr<=idx; then IDLE.
//    Minimum grant-to-grant spacing is 4 cycles.
//  Inhibit rising during GRANT/HOLD does not revoke the grant; it only blocks the next grant.
//  Simultaneous multiple requests: exactly one winner, strict rotation, no starvation.
//  busy=1 in GRANT/HOLD/RECOVER.
//  rst_n asserted mid-grant: outputs clear immediately (async), ptr returns to NREQ-1.
// CONFIGURATION
//  CU_ARB_TIMEOUT_EN defined:
//    - Hold counter increments each HOLD cycle.
//    - On reaching MAX_HOLD-1 with no release, go to RECOVER and pulse timeout.
//    - A release on the same cycle as the timeout wins: no timeout pulse.
//  CU_ARB_TIMEOUT_EN undefined: no counter; timeout tied to 0; a grant is held indefinitely.
// STRUCTURE
//  Package cu_arb_pkg:
//    - state enum (IDLE, GRANT, HOLD, RECOVER)
//    - IDX_W localparam function
//    - MAX_HOLD default constant
//  Sub-module cu_rr_pick: combinational rotating priority encoder
//    (req, ptr -> winner one-hot + index + any).
//  Top contains the FSM, registered outputs, ptr, and the optional hold counter.
// TESTING
//  1 Reset, then req=4'b0001 at cycle 0:
//    - gnt=0001, gnt_idx=0, strobe=1 at cycle 1
//    - rel[0] at cycle 3 -> gnt=0 at cycle 4, busy=0 at cycle 5
//  2 req=4'b1111 held, release every grant on its first HOLD cycle:
//    - grant order 0,1,2,3,0
//    - strobe every 4 cycles
//  3 inhibit=1 with req=4'b0100: no grant. Deassert inhibit -> gnt=0100 one cycle later.
//    inhibit raised during HOLD: grant kept until rel.
//  4 Owner drops req[idx] in HOLD without rel -> RECOVER.
//    Other req bits toggling in HOLD do not change gnt.
//  5 CU_ARB_TIMEOUT_EN, MAX_HOLD=16, owner never releases:
//    - timeout pulse and revoke after 16 HOLD-phase cycles, then next requester granted
//    - without the macro: grant held for 1000 cycles, timeout=0
//  6 rst_n low during HOLD:
//    - gnt, gnt_vld, busy = 0 asynchronously
//    - after reset, req=1111 -> requester 0 wins

Source files
------------

// File: rtl/cu_arb_pkg.sv
// Shared types and constants for the cu strobe arbiter.
package cu_arb_pkg;

  // Arbiter phases: wait for a request, strobe once, hold, one dead cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLD    = 2'd2,
    RECOVER = 2'd3
  } arb_state_e;

  // Default watchdog limit in cycles; only meaningful with CU_ARB_TIMEOUT_EN.
  localparam int MAX_HOLD_DEF = 16;

  // Width of an encoded requester index (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cu_rr_pick.sv
// Rotating priority encoder: the first set request bit after ptr (mod NREQ) wins.
module cu_rr_pick
  import cu_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the candidate closest to ptr+1 is the last write.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    win     = '0;
    any     = |req;
    for (int k = NREQ; k >= 1; k--) begin
      cand = ptr + IW'(k);
      if (req[cand]) win_idx = cand;
    end
    if (any) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/cu_strobe_arbiter.sv
// Round-robin owner of the cu decode strobe path.
// Optional grant watchdog enabled by defining CU_ARB_TIMEOUT_EN.
module cu_strobe_arbiter
  import cu_arb_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  localparam int IW       = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] rel,
  input  logic            inhibit,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld,
  output logic            strobe,
  output logic            busy,
  output logic            timeout
);

  // Reject configurations the rotation arithmetic does not support.
  if (NREQ < 2 || NREQ > 8 || (NREQ & (NREQ - 1)) != 0 || MAX_HOLD < 2) begin : g_bad_cfg
    $error("cu_strobe_arbiter: NREQ must be a power of two in 2..8 and MAX_HOLD >= 2");
  end

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            rel_pend_q, rel_pend_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic            gnt_vld_q, gnt_vld_d;
  logic            strobe_q, strobe_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] pick_win;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            owner_done;
  logic            hold_expired;

  cu_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Owner is finished on its release pulse, on dropping its request, or on a
  // release that arrived during the strobe cycle.
  assign owner_done = rel[owner_q] | ~req[owner_q] | rel_pend_q;

`ifdef CU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  assign hold_expired = (cnt_q == CW'(MAX_HOLD - 1));

  // Watchdog: counts HOLD cycles; a release in the expiry cycle suppresses the pulse.
  always_comb begin
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (state_q == HOLD) begin
      cnt_d     = cnt_q + CW'(1);
      timeout_d = hold_expired & ~owner_done;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Next-state: grant only from IDLE, leave HOLD on release or watchdog expiry.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    rel_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!inhibit && pick_any) begin
          state_d = GRANT;
          owner_d = pick_idx;
        end
      end
      GRANT: begin
        state_d    = HOLD;
        rel_pend_d = rel[owner_q];
      end
      HOLD: begin
        if (owner_done || hold_expired) state_d = RECOVER;
      end
      RECOVER: begin
        state_d = IDLE;
        ptr_d   = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    gnt_d     = '0;
    gnt_idx_d = '0;
    gnt_vld_d = 1'b0;
    if (state_d == GRANT) begin
      gnt_d = pick_win;
    end else if (state_d == HOLD) begin
      gnt_d = gnt_q;
    end
    if (state_d == GRANT || state_d == HOLD) begin
      gnt_idx_d = owner_d;
      gnt_vld_d = 1'b1;
    end
    strobe_d = (state_d == GRANT);
    busy_d   = (state_d != IDLE);
  end

  // State, rotation pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(NREQ - 1);
      owner_q    <= '0;
      rel_pend_q <= 1'b0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      rel_pend_q <= rel_pend_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign strobe  = strobe_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_cu_strobe_arbiter.sv
// Directed bench for cu_strobe_arbiter with a cycle-level behavioural model.
// Watchdog checks follow CU_ARB_TIMEOUT_EN.
module tb_cu_strobe_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 16;
`ifdef CU_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] rel = '0;
  logic       inhibit = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld, strobe, busy, timeout;

  int n_checks = 0;
  int n_errors = 0;

  cu_strobe_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .rel     (rel),
    .inhibit (inhibit),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .strobe  (strobe),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_owner: current owner (-1 none); m_age: 0 in the strobe cycle, k in the k-th
  // hold cycle; m_dead: the single dead cycle after a grant ends.
  int m_owner = -1;
  int m_age   = 0;
  int m_ptr   = NREQ - 1;
  bit m_dead  = 1'b0;
  bit m_to    = 1'b0;
  bit m_pend  = 1'b0;

  always @(posedge clk) begin
    bit   released, timed;
    logic [3:0] e_gnt;
    if (!rst_n) begin
      m_owner = -1; m_age = 0; m_ptr = NREQ - 1;
      m_dead = 1'b0; m_to = 1'b0; m_pend = 1'b0;
    end else if (m_dead) begin
      m_dead = 1'b0; m_to = 1'b0; m_owner = -1;
    end else if (m_owner >= 0) begin
      if (m_age == 0) begin
        m_pend = rel[m_owner];
        m_age  = 1;
      end else begin
        released = rel[m_owner] || !req[m_owner] || m_pend;
        timed    = TO_ON && (m_age >= MAX_HOLD);
        m_pend   = 1'b0;
        if (released || timed) begin
          m_dead = 1'b1;
          m_to   = !released;
          m_ptr  = m_owner;
        end else begin
          m_age++;
        end
      end
    end else if (!inhibit && req != 4'b0000) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (req[c] && m_owner < 0) begin
          m_owner = c;
          m_age   = 0;
        end
      end
    end
    #1;
    e_gnt = (m_owner >= 0 && !m_dead) ? (4'b0001 << m_owner) : 4'b0000;
    chk("mdl_gnt", 32'(gnt), 32'(e_gnt));
    chk("mdl_idx", 32'(gnt_idx), (m_owner >= 0 && !m_dead) ? m_owner : 0);
    chk("mdl_vld", 32'(gnt_vld), 32'(m_owner >= 0 && !m_dead));
    chk("mdl_strobe", 32'(strobe), 32'(m_owner >= 0 && !m_dead && m_age == 0));
    chk("mdl_busy", 32'(busy), 32'(m_owner >= 0));
    chk("mdl_timeout", 32'(timeout), 32'(m_dead && m_to));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; rel = '0; inhibit = 1'b0; rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [3:0] oh;
    tick(2);
    rst_n = 1'b1;
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_busy", 32'(busy), 0);
    tick(2);

    // 1: single requester, release in second hold cycle
    req = 4'b0001;
    tick(); chk("t1_gnt", 32'(gnt), 'h1); chk("t1_idx", 32'(gnt_idx), 0);
    chk("t1_strobe", 32'(strobe), 1);
    tick(); chk("t1_hold_strobe", 32'(strobe), 0); chk("t1_hold_gnt", 32'(gnt), 'h1);
    tick(); rel = 4'b0001;
    tick(); rel = '0; req = '0;
    chk("t1_rec_gnt", 32'(gnt), 0); chk("t1_rec_busy", 32'(busy), 1);
    tick(); chk("t1_idle_busy", 32'(busy), 0);
    tick();
    $display("test 1 single grant done");

    // 2: all requesting, strict rotation 0,1,2,3,0 every 4 cycles
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      tick(); chk("t2_strobe", 32'(strobe), 1); chk("t2_idx", 32'(gnt_idx), i % 4);
      chk("t2_gnt", 32'(gnt), 32'(oh));
      tick(); rel = oh;
      tick(); rel = '0; chk("t2_rec_vld", 32'(gnt_vld), 0);
      tick(); chk("t2_idle_busy", 32'(busy), 0);
      if (i == 4) req = '0;
    end
    tick();
    $display("test 2 rotation done");

    // 3: inhibit blocks new grants but not an active one
    do_reset();
    inhibit = 1'b1; req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t3_inh_vld", 32'(gnt_vld), 0);
    end
    inhibit = 1'b0;
    tick(); chk("t3_gnt", 32'(gnt), 'h4); chk("t3_idx", 32'(gnt_idx), 2);
    tick(); inhibit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t3_kept_gnt", 32'(gnt), 'h4);
    end
    rel = 4'b0100;
    tick(); rel = '0; chk("t3_rec_vld", 32'(gnt_vld), 0);
    tick(); chk("t3_idle_busy", 32'(busy), 0);
    tick(); chk("t3_blocked_vld", 32'(gnt_vld), 0);
    inhibit = 1'b0; req = '0;
    tick();
    $display("test 3 inhibit done");

    // 4: request drop as release, foreign bits ignored, release during strobe deferred
    do_reset();
    req = 4'b0010;
    tick(); chk("t4_idx", 32'(gnt_idx), 1);
    tick(); req = 4'b1011; rel = 4'b1101;
    tick(); chk("t4_noise_gnt", 32'(gnt), 'h2); req = 4'b0110; rel = '0;
    tick(); chk("t4_noise2_gnt", 32'(gnt), 'h2); req = 4'b0100;
    tick(); chk("t4_drop_vld", 32'(gnt_vld), 0); chk("t4_drop_busy", 32'(busy), 1);
    tick(); chk("t4_idle_busy", 32'(busy), 0);
    tick(); chk("t4_next_idx", 32'(gnt_idx), 2); chk("t4_next_gnt", 32'(gnt), 'h4);
    rel = 4'b0100;
    tick(); rel = '0; chk("t4_defer_vld", 32'(gnt_vld), 1);
    tick(); chk("t4_defer_rec", 32'(gnt_vld), 0);
    req = '0;
    tick(2);
    $display("test 4 drop/defer done");

    // 5: owner never releases
    do_reset();
    req = 4'b0011;
    tick(); chk("t5_idx", 32'(gnt_idx), 0); chk("t5_strobe", 32'(strobe), 1);
`ifdef CU_ARB_TIMEOUT_EN
    for (int k = 1; k <= MAX_HOLD; k++) begin
      tick(); chk("t5_hold_vld", 32'(gnt_vld), 1); chk("t5_hold_to", 32'(timeout), 0);
    end
    tick(); chk("t5_to_pulse", 32'(timeout), 1); chk("t5_to_vld", 32'(gnt_vld), 0);
    tick(); chk("t5_to_clear", 32'(timeout), 0); chk("t5_to_busy", 32'(busy), 0);
    tick(); chk("t5_next_idx", 32'(gnt_idx), 1); chk("t5_next_strobe", 32'(strobe), 1);
    tick(MAX_HOLD); rel = 4'b0010; req = '0;
    tick(); chk("t5_race_to", 32'(timeout), 0); chk("t5_race_vld", 32'(gnt_vld), 0);
    rel = '0;
    tick(2);
`else
    tick(1000);
    chk("t5_long_vld", 32'(gnt_vld), 1); chk("t5_long_idx", 32'(gnt_idx), 0);
    chk("t5_long_to", 32'(timeout), 0);
    req = '0;
    tick(); chk("t5_drop_vld", 32'(gnt_vld), 0);
    tick(2);
`endif
    $display("test 5 watchdog done");

    // 6: async reset mid-hold returns pointer to its reset value
    do_reset();
    req = 4'b0010;
    tick(); chk("t6_first_idx", 32'(gnt_idx), 1);
    tick(); rel = 4'b0010; req = '0;
    tick(); rel = '0;
    tick(); req = 4'b0001;
    tick(); chk("t6_second_idx", 32'(gnt_idx), 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(gnt), 0); chk("t6_async_vld", 32'(gnt_vld), 0);
    chk("t6_async_busy", 32'(busy), 0);
    tick(2);
    rst_n = 1'b1; req = 4'b1111;
    tick(); chk("t6_after_idx", 32'(gnt_idx), 0); chk("t6_after_strobe", 32'(strobe), 1);
    tick(); rel = 4'b0001; req = '0;
    tick(); rel = '0;
    tick(2);
    $display("test 6 async reset done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
